// File: rtl/vga_plot_if.sv
// ============================================================================
// Module   : vga_plot_if
// Brief    : Plot/clear command bus between a drawing client and the receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_plot_if #(
    parameter int XW = 8,
    parameter int YW = 7
);
    logic [XW-1:0] VGA_X;
    logic [YW-1:0] VGA_Y;
    logic [2:0]    VGA_COLOR;
    logic          plot;
    logic          clear;
    logic [2:0]    bg_color;
    logic          busy;
    logic [7:0]    drop_count;

    modport master (
        output VGA_X, VGA_Y, VGA_COLOR, plot, clear, bg_color,
        input  busy, drop_count
    );

    modport slave (
        input  VGA_X, VGA_Y, VGA_COLOR, plot, clear, bg_color,
        output busy, drop_count
    );
endinterface

`default_nettype wire

// File: rtl/vga_plot_receiver.sv
// ============================================================================
// Module   : vga_plot_receiver
// Brief    : 3-bit framebuffer with plot/clear writer and 640x480 VGA scan-out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_plot_receiver #(
    parameter int H_RES = 160,
    parameter int V_RES = 120,
    parameter int XW    = 8,
    parameter int YW    = 7
) (
    input  wire logic       CLOCK_50,
    input  wire logic       Reset,
    vga_plot_if.slave       bus,
    output logic            VGA_HS,
    output logic            VGA_VS,
    output logic            VGA_BLANK_N,
    output logic [2:0]      VGA_RGB
);
    localparam int DEPTH  = H_RES * V_RES;
    localparam int AW     = $clog2(DEPTH);
    localparam int HSHIFT = $clog2(640 / H_RES);
    localparam int VSHIFT = $clog2(480 / V_RES);
    localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [2:0]      mem [0:DEPTH-1];

    logic [XW-1:0]   w_x;
    logic [YW-1:0]   w_y;
    logic            w_in_range;
    logic            w_plot_ok;
    logic            w_drop;
    logic [AW-1:0]   w_plot_addr;

    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [2:0]      r_wr_data;
    logic [AW-1:0]   r_fill_addr;
    logic [2:0]      r_bg;
    logic [7:0]      r_drop;

    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [2:0]      w_wdata;

    logic            r_pix_en;
    logic [9:0]      r_h;
    logic [9:0]      r_v;

    logic            w_vis;
    logic [AW-1:0]   w_raddr;
    logic [AW-1:0]   r_raddr;
    logic            r_blank1, r_hs1, r_vs1;
    logic            r_blank2, r_hs2, r_vs2;
    logic [2:0]      r_rgb;

    assign w_x         = bus.VGA_X;
    assign w_y         = bus.VGA_Y;
    assign w_in_range  = (32'(w_x) < H_RES) && (32'(w_y) < V_RES);
    assign w_plot_addr = AW'(w_y) * AW'(H_RES) + AW'(w_x);

    always_ff @(posedge CLOCK_50) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Clear wins over plot in IDLE; any plot not accepted is a drop.
    always_comb begin
        w_state_next = r_state;
        w_plot_ok    = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.clear) w_state_next = CLEAR;
                w_plot_ok = bus.plot && !bus.clear && w_in_range;
                w_drop    = bus.plot && !w_plot_ok;
            end
            CLEAR: begin
                if (r_fill_addr == C_LAST) w_state_next = IDLE;
                w_drop = bus.plot;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_fill_addr <= '0;
            r_bg        <= '0;
            r_drop      <= '0;
        end else begin
            r_wr_en   <= w_plot_ok;
            r_wr_addr <= w_plot_addr;
            r_wr_data <= bus.VGA_COLOR;
            if (r_state == IDLE && bus.clear) begin
                r_fill_addr <= '0;
                r_bg        <= bus.bg_color;
            end else if (r_state == CLEAR) begin
                r_fill_addr <= r_fill_addr + AW'(1);
            end
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    assign bus.busy       = (r_state == CLEAR);
    assign bus.drop_count = r_drop;

    // A pending plot write can never coincide with CLEAR, so the mux is safe.
    assign w_we    = !Reset && ((r_state == CLEAR) || r_wr_en);
    assign w_waddr = (r_state == CLEAR) ? r_fill_addr : r_wr_addr;
    assign w_wdata = (r_state == CLEAR) ? r_bg : r_wr_data;

    always_ff @(posedge CLOCK_50) begin
        if (w_we) mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_pix_en <= 1'b0;
            r_h      <= '0;
            r_v      <= '0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                if (r_h == 10'd799) begin
                    r_h <= '0;
                    r_v <= (r_v == 10'd524) ? 10'd0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
        end
    end

    assign w_vis   = (r_h < 10'd640) && (r_v < 10'd480);
    assign w_raddr = w_vis ? (AW'(r_v >> VSHIFT) * AW'(H_RES) + AW'(r_h >> HSHIFT)) : '0;

    // Syncs travel alongside the read address/data so all outputs stay aligned.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_raddr  <= '0;
            r_blank1 <= 1'b0;
            r_hs1    <= 1'b1;
            r_vs1    <= 1'b1;
            r_blank2 <= 1'b0;
            r_hs2    <= 1'b1;
            r_vs2    <= 1'b1;
            r_rgb    <= '0;
        end else begin
            r_raddr  <= w_raddr;
            r_blank1 <= w_vis;
            r_hs1    <= !((r_h >= 10'd656) && (r_h <= 10'd751));
            r_vs1    <= !((r_v >= 10'd490) && (r_v <= 10'd491));
            r_blank2 <= r_blank1;
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
            r_rgb    <= r_blank1 ? mem[r_raddr] : 3'b000;
        end
    end

    assign VGA_HS      = r_hs2;
    assign VGA_VS      = r_vs2;
    assign VGA_BLANK_N = r_blank2;
    assign VGA_RGB     = r_rgb;

endmodule

`default_nettype wire

// File: doc/vga_plot_receiver.md
VGA_PLOT_RECEIVER -- requirements
Module: vga_plot_receiver

Interface
REQ-001 Parameter H_RES, default 160, framebuffer width in pixels (160, 320 or 640).
REQ-002 Parameter V_RES, default 120, framebuffer height in pixels (120, 240 or 480).
REQ-003 Parameter XW, default 8, plot X bit width; YW, default 7, plot Y bit width.
REQ-004 CLOCK_50  in  1  single clock, 50 MHz; all state on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 VGA_X  in  XW  plot column.
REQ-007 VGA_Y  in  YW  plot row.
REQ-008 VGA_COLOR  in  3  plot color {R,G,B}.
REQ-009 plot  in  1  write strobe; one pixel write per high cycle.
REQ-010 clear  in  1  pulse; start fill of whole framebuffer with bg_color.
REQ-011 bg_color  in  3  fill color, sampled on the cycle clear is accepted.
REQ-012 busy  out  1  high while clear fill runs.
REQ-013 drop_count  out  8  count of rejected plot strobes, saturating at 255.
REQ-014 VGA_HS, VGA_VS  out  1 each  sync, active low.
REQ-015 VGA_BLANK_N  out  1  high in visible region.
REQ-016 VGA_RGB  out  3  scan-out pixel color; 0 when blanked.

Function
REQ-017 Framebuffer SHALL hold H_RES*V_RES 3-bit entries, one write port, one read port; address = y*H_RES + x.
REQ-018 States SHALL be IDLE and CLEAR; Reset -> IDLE.
REQ-019 IDLE: plot high with VGA_X < H_RES and VGA_Y < V_RES -> write VGA_COLOR at (x,y) in the next cycle (1-cycle registered write).
REQ-020 IDLE: plot high with VGA_X >= H_RES or VGA_Y >= V_RES -> no write; drop_count +1 (saturate).
REQ-021 IDLE: clear high -> CLEAR, latch bg_color, fill address to 0, busy high next cycle; clear takes priority over plot in the same cycle (plot counted as dropped).
REQ-022 CLEAR: one address per clock, 0 to H_RES*V_RES-1; after the last write -> IDLE, busy low the following cycle; fill takes exactly H_RES*V_RES cycles.
REQ-023 CLEAR: plot strobes SHALL be ignored and counted in drop_count; clear re-asserted is ignored.
REQ-024 Pixel enable SHALL toggle every clock (25 MHz pixel rate); raster counters advance only on enable.
REQ-025 hcount 0..799, wraps to 0; vcount 0..524, advances when hcount wraps, wraps to 0 after 524.
REQ-026 Visible: hcount<640 and vcount<480; HS low for hcount 656..751; VS low for vcount 490..491.
REQ-027 Read address SHALL be (vcount/(480/V_RES))*H_RES + hcount/(640/H_RES); scale factors are powers of two (shift only).
REQ-028 Read pipeline: address registered (stage 1), RAM read registered (stage 2); HS, VS, BLANK_N SHALL be delayed by the same two clocks so all four outputs describe the same raster position.
REQ-029 Same-address write and read in one cycle: read returns the old value.
REQ-030 Scan-out SHALL run continuously, including during CLEAR; no stall or handshake.

Reset
REQ-031 Reset SHALL set hcount=vcount=0, state=IDLE, busy=0, drop_count=0, VGA_HS=VGA_VS=1, VGA_BLANK_N=0, VGA_RGB=0, pipeline stages cleared.
REQ-032 Reset mid-CLEAR SHALL abort the fill; framebuffer contents are not reset and are undefined until written.
REQ-033 Reset asserted with plot high SHALL suppress that write.

Verification
REQ-034 Reset, clear with bg_color=3'b001, wait busy low -> busy high exactly 19200 cycles; every visible VGA_RGB = 001.
REQ-035 After clear, plot (x=5,y=7,color=3'b110) -> visible pixels h 20..23, v 28..31 show 110; neighbours show 001.
REQ-036 plot (x=160,y=0) then (x=0,y=120) -> drop_count=2, no framebuffer change; 300 bad plots -> drop_count=255.
REQ-037 Free-run one frame -> HS period 1600 clocks, HS low 192 clocks; VS period 840000 clocks, VS low 3200 clocks; BLANK_N high 1280 clocks per visible line.
REQ-038 plot during CLEAR, and clear+plot same cycle -> plot ignored, drop_count increments, fill completes with bg_color.
REQ-039 Reset at fill address 100 -> busy=0 and all outputs at reset values next cycle; new clear then completes normally.
